// File: rtl/gcd_lcm_unit.sv
// Iterative GCD/LCM coprocessor unit: GCD by repeated subtraction, LCM by
// dual running multiples, one step per cycle, holding the core via stall.
//
// Ports:
//   clk, reset    - core clock, synchronous active-high reset
//   start, op     - instruction present (level), 0 = GCD / 1 = LCM
//   a, b          - unsigned operands rs1/rs2
//   stall         - combinational PC/fetch hold
//   busy, done    - registered RUN flag, one-cycle result-valid pulse
//   result, ovf   - registered result and LCM overflow flag
module gcd_lcm_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   x_q, x_d;
    logic [WIDTH:0]   y_q, y_d;
    logic [WIDTH-1:0] al_q, al_d;
    logic [WIDTH-1:0] bl_q, bl_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    // x/y never exceed 2^WIDTH-1 while running, so these sums cannot wrap;
    // bit WIDTH of a sum flags LCM overflow.
    logic [WIDTH:0] sum_x;
    logic [WIDTH:0] sum_y;

    assign sum_x = x_q + {1'b0, al_q};
    assign sum_y = y_q + {1'b0, bl_q};

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        al_d     = al_q;
        bl_d     = bl_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d   = {1'b0, a};
                    y_d   = {1'b0, b};
                    al_d  = a;
                    bl_d  = b;
                    op_d  = op;
                    ovf_d = 1'b0;
                    if (a == '0 || b == '0) begin
                        result_d = op ? '0 : (a | b);
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (x_q == y_q) begin
                    result_d = x_q[WIDTH-1:0];
                    state_d  = S_DONE;
                end else if (!op_q) begin
                    if (x_q > y_q) begin
                        x_d = x_q - y_q;
                    end else begin
                        y_d = y_q - x_q;
                    end
                end else if (x_q < y_q) begin
                    x_d = sum_x;
                    if (sum_x[WIDTH]) begin
                        result_d = '0;
                        ovf_d    = 1'b1;
                        state_d  = S_DONE;
                    end
                end else begin
                    y_d = sum_y;
                    if (sum_y[WIDTH]) begin
                        result_d = '0;
                        ovf_d    = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            al_q     <= '0;
            bl_q     <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            al_q     <= al_d;
            bl_q     <= bl_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign stall  = ((state_q == S_IDLE) && start) || (state_q == S_RUN);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Self-checking bench for gcd_lcm_unit: directed cases plus randomized
// operands checked against an arithmetic GCD/LCM reference model.
module tb_gcd_lcm_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    gcd_lcm_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("check %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: Euclid by division; the subtractive machine performs
    // (sum of quotients - 1) subtractions, the multiples machine performs
    // (L/a - 1) + (L/b - 1) additions. Done arrives at steps + 2 cycles.
    function automatic longint unsigned m_gcd(input longint unsigned x,
                                              input longint unsigned y);
        longint unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int m_gcd_lat(input longint unsigned x,
                                     input longint unsigned y);
        longint unsigned t;
        longint unsigned s;
        if (x == 0 || y == 0) return 1;
        s = 0;
        while (y != 0) begin
            s += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return int'(s - 1) + 2;
    endfunction

    task automatic run_op(input string tag, input logic o,
                          input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb,
                          input logic [WIDTH-1:0] exp_res,
                          input logic exp_ovf, input int exp_lat);
        int n;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        #1;
        chk({tag, "_stall_req"}, 64'(stall), 64'd1);
        seen = 0;
        n    = 0;
        while (!seen && n < 5000) begin
            @(negedge clk);
            n++;
            a = $urandom;
            b = $urandom;
            if (n == 1 && exp_lat > 1)
                chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_result"}, 64'(result), 64'(exp_res));
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        chk({tag, "_stall_done"}, 64'(stall), 64'd0);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_held"}, 64'(result), 64'(exp_res));
    endtask

    task automatic run_model(input string tag, input logic o,
                             input logic [WIDTH-1:0] va,
                             input logic [WIDTH-1:0] vb);
        longint unsigned g;
        longint unsigned l;
        int lat;
        logic [WIDTH-1:0] r;
        if (va == 0 || vb == 0) begin
            r   = o ? '0 : (va | vb);
            lat = 1;
        end else begin
            g = m_gcd(va, vb);
            if (!o) begin
                r   = WIDTH'(g);
                lat = m_gcd_lat(va, vb);
            end else begin
                l   = (longint'(va) * longint'(vb)) / g;
                r   = WIDTH'(l);
                lat = int'(l / va + l / vb);
            end
        end
        run_op(tag, o, va, vb, r, 1'b0, lat);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd5;
        b     = 32'd7;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        start = 1'b0;
        #1;
        chk("rst_stall_low", 64'(stall), 64'd0);
        start = 1'b1;
        #1;
        @(posedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        start = 1'b1;
        #1;
        chk("post_rst_stall", 64'(stall), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);
        start = 1'b0;
        @(negedge clk);

        run_op("gcd_12_8", 1'b0, 32'd12, 32'd8, 32'd4, 1'b0, 4);
        run_op("lcm_4_6", 1'b1, 32'd4, 32'd6, 32'd12, 1'b0, 5);
        run_op("gcd_0_9", 1'b0, 32'd0, 32'd9, 32'd9, 1'b0, 1);
        run_op("lcm_7_0", 1'b1, 32'd7, 32'd0, 32'd0, 1'b0, 1);
        run_op("gcd_0_0", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1);
        run_op("lcm_ovf", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
               32'd0, 1'b1, 2);
        run_op("lcm_after_ovf", 1'b1, 32'd3, 32'd5, 32'd15, 1'b0,
               int'(15 / 3 + 15 / 5));

        // Reset in the middle of a long GCD: no done pulse afterwards.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd1;
        b     = 32'd1000;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5) chk("mid_busy", 64'(busy), 64'd1);
        end
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        begin
            bit pulsed;
            pulsed = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done || busy) pulsed = 1;
            end
            chk("mid_rst_quiet", 64'(pulsed), 64'd0);
        end
        run_model("gcd_6_9", 1'b0, 32'd6, 32'd9);

        for (int i = 0; i < 24; i++) begin
            logic o;
            logic [WIDTH-1:0] va;
            logic [WIDTH-1:0] vb;
            o  = 1'($urandom_range(0, 1));
            va = ($urandom_range(0, 7) == 0) ? '0 : $urandom_range(1, 255);
            vb = ($urandom_range(0, 7) == 0) ? '0 : $urandom_range(1, 255);
            run_model($sformatf("rnd%0d", i), o, va, vb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
